// File: rtl/bcd_counter_ctrl_if.sv
// Control/status bundle between the sequencer and its environment
// (buttons/switches on the input side, the BCD digit chain on both sides).
interface bcd_counter_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  load_req;
    logic                  dir_in;
    logic                  one_shot;
    logic [4*DIGITS-1:0]   preset;
    logic [4*DIGITS-1:0]   count_in;
    logic                  cnt_en;
    logic                  load;
    logic [DIGITS-1:0]     sel;
    logic [3:0]            ld_data;
    logic                  up_down;
    logic                  busy;
    logic                  done;
    logic [2:0]            state;

    // Environment side: drives requests and digit feedback, observes controls.
    modport master (
        output start, stop, load_req, dir_in, one_shot, preset, count_in,
        input  cnt_en, load, sel, ld_data, up_down, busy, done, state
    );

    // Sequencer side.
    modport slave (
        input  start, stop, load_req, dir_in, one_shot, preset, count_in,
        output cnt_en, load, sel, ld_data, up_down, busy, done, state
    );
endinterface

// File: rtl/bcd_counter_ctrl.sv
// Sequencer for a cascade of BCD up/down digits: prescaled count tick,
// digit-by-digit preset load, latched direction and one-shot terminal stop.
module bcd_counter_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    bcd_counter_ctrl_if.slave  bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic                r_cnt_en;
    logic                r_load;
    logic [DIGITS-1:0]   r_sel;
    logic [3:0]          r_ld_data;
    logic                r_up_down;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic                w_all9;
    logic                w_all0;
    logic                w_terminal;
    logic [IW-1:0]       w_nxt_idx;

    // Terminal count detection on the fed-back digit values.
    always_comb begin
        w_all9 = 1'b1;
        w_all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.count_in[4*i +: 4] != 4'd9) w_all9 = 1'b0;
            if (bus.count_in[4*i +: 4] != 4'd0) w_all0 = 1'b0;
        end
        w_terminal = r_up_down ? w_all0 : w_all9;
    end

    assign w_tick    = (r_pre == PW'(TICK_DIV - 1));
    assign w_nxt_idx = r_idx + IW'(1);

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_idx     <= '0;
            r_cnt_en  <= 1'b0;
            r_load    <= 1'b0;
            r_sel     <= '0;
            r_ld_data <= '0;
            r_up_down <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cnt_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_req) begin
                        r_state   <= S_LOAD;
                        r_idx     <= '0;
                        r_load    <= 1'b1;
                        r_sel     <= DIGITS'(1);
                        r_ld_data <= bus.preset[3:0];
                        r_busy    <= 1'b1;
                    end else if (bus.start && !bus.stop) begin
                        r_state   <= S_RUN;
                        r_up_down <= bus.dir_in;
                        r_pre     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_idx == IW'(DIGITS - 1)) begin
                        r_state   <= S_IDLE;
                        r_idx     <= '0;
                        r_load    <= 1'b0;
                        r_sel     <= '0;
                        r_ld_data <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_idx     <= w_nxt_idx;
                        r_sel     <= DIGITS'(1) << w_nxt_idx;
                        r_ld_data <= bus.preset[{w_nxt_idx, 2'b00} +: 4];
                    end
                end
                S_RUN: begin
                    // The stop cycle still advances the prescaler; it is frozen
                    // from PAUSE on, so a tick swallowed by stop resumes with a
                    // full period.
                    r_pre <= w_tick ? '0 : r_pre + PW'(1);
                    if (bus.stop) begin
                        r_state <= S_PAUSE;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        if (bus.one_shot && w_terminal) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt_en <= 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.load_req) begin
                        r_state   <= S_LOAD;
                        r_idx     <= '0;
                        r_load    <= 1'b1;
                        r_sel     <= DIGITS'(1);
                        r_ld_data <= bus.preset[3:0];
                        r_busy    <= 1'b1;
                    end else if (bus.start && !bus.stop) begin
                        r_state   <= S_RUN;
                        r_up_down <= bus.dir_in;
                        r_busy    <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.load_req) begin
                        r_state   <= S_LOAD;
                        r_idx     <= '0;
                        r_load    <= 1'b1;
                        r_sel     <= DIGITS'(1);
                        r_ld_data <= bus.preset[3:0];
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end else if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_load  <= 1'b0;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    assign bus.cnt_en  = r_cnt_en;
    assign bus.load    = r_load;
    assign bus.sel     = r_sel;
    assign bus.ld_data = r_ld_data;
    assign bus.up_down = r_up_down;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.state   = r_state;
endmodule
